word_receiver: RTL and testbench
================================

# word_receiver

Serial-to-parallel capture stage that sits directly upstream of the byte transmitter in the JTAG data path. It samples one bit per enabled cycle, MSB first, and assembles a WIDTH-bit word. It then presents the word to the consumer with a valid/ack handshake. Bit order matches the transmitter, so a word received here and handed to it is re-emitted in the original order.

## Interface
- WIDTH, 32: word length in bits; legal range 2..64. Derived: CW = $clog2(WIDTH+1) for the bit counter.

- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  reset; synchronous and active-low.
- enable  input  1  when high, `in` is sampled this cycle.
- in  input  1  serial data bit.
- clear  input  1  abandons the partial word in progress; the held output word is kept.
- ack  input  1  consumer accepts `data`; meaningful only while `valid` is high.
- data  output  WIDTH  last completed word; MSB is the first bit received.
- valid  output  1  `data` holds an unacknowledged word.
- busy  output  1  a partial word is in progress (state SHIFT).
- overrun  output  1  sticky flag: a completed word was dropped.
- bit_count  output  CW  number of bits collected in the current partial word.

## Operation
- Storage is split into two registers: a shift register `sh` (WIDTH-1 bits) and an output register `data`. Reception continues while `data` is held.
- The state machine has two states:
  - IDLE, with bit_count == 0. An enabled sample moves the block to SHIFT.
  - SHIFT. It returns to IDLE on word completion or on `clear`.
- Enabled sample with bit_count < WIDTH-1:
  - sh <= {sh[WIDTH-3:0], in};
  - bit_count <= bit_count+1.
- Enabled sample with bit_count == WIDTH-1 completes the word:
  - completed word = {sh, in};
  - bit_count <= 0, state <= IDLE.
- Word completion outcome:
  - If valid == 0, or ack is high this cycle: data <= completed word, valid <= 1.
  - Otherwise the completed word is discarded, data is unchanged, and overrun <= 1.
- ack with valid high and no completion this cycle: valid <= 0.
- ack with valid low: ignored.
- clear:
  - bit_count <= 0, state <= IDLE, and the enabled bit that cycle is discarded.
  - clear has priority over completion; no word is produced that cycle.
  - data, valid and overrun are unaffected.
- overrun is cleared only by rst_n.
- Counter arithmetic is unsigned CW bits. bit_count never exceeds WIDTH-1 and never wraps.

## Timing
- Reset, applied on an edge with rst_n low:
  - data = 0, valid = 0, busy = 0, overrun = 0, bit_count = 0, sh = 0.
  - Reset overrides every other input.
  - Reset mid-word discards the partial word and any held word.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: valid rises on the edge that samples the WIDTH-th enabled bit, so `data` is visible the following cycle.
- Enable gaps of any length are permitted; bit_count and sh hold while enable is low.
- Back-to-back words with continuous enable are supported. A new word completes every WIDTH cycles. The consumer must ack within WIDTH cycles of valid rising to avoid overrun.
- ack and completion in the same cycle: the new word is loaded and valid stays 1, with no gap and no overrun.
- busy = (state == SHIFT) and rises one cycle after the first enabled bit.

## Test plan
- Serial word with continuous enable: shift 0xDEADBEEF MSB first over 32 enabled cycles.
  - Required: after the 32nd edge, valid = 1 and data = 0xDEADBEEF.
  - Required: bit_count = 0 and busy = 0.
- Enable gaps: send 0x80000001 with enable toggled 1,0,1,0,…
  - Required: valid rises only after the 32nd enabled sample and data = 0x80000001.
  - Required: bit_count holds during low-enable cycles.
- Ack coincident with completion: with 0x12345678 held unacknowledged, stream 0xCAFEF00D and assert ack on the cycle its 32nd bit is sampled.
  - Required: data = 0xCAFEF00D, valid stays 1, overrun = 0.
- Overrun: with 0x11111111 held unacknowledged, complete 0x22222222 without ack.
  - Required: data = 0x11111111, valid = 1, overrun = 1.
  - Required: after ack, valid = 0 and overrun stays 1.
- Clear mid-word: shift 10 bits of 1s, then assert clear together with enable.
  - Required: bit_count = 0 and busy = 0.
  - Required: the next 32 bits of 0x0F0F0F0F yield data = 0x0F0F0F0F.
- Reset mid-word: with a held word 0xAAAAAAAA and 20 bits of a partial word, pull rst_n low for one edge.
  - Required: all outputs are 0.
  - Required: a subsequent full 0x55555555 stream yields data = 0x55555555.

Source files
------------

// File: rtl/word_receiver_if.sv
// Handshake/bus bundle between the word receiver and its producer/consumer.
// The master side drives the serial stream and the ack; the slave side is
// the receiver itself, which returns the assembled word and status.
interface word_receiver_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
);

  logic             enable;     // sample din this cycle
  logic             din;        // serial data bit
  logic             clear;      // abandon the partial word
  logic             ack;        // consumer accepts data
  logic [WIDTH-1:0] data;       // last completed word, MSB received first
  logic             valid;      // data holds an unacknowledged word
  logic             busy;       // a partial word is in progress
  logic             overrun;    // sticky: a completed word was dropped
  logic [CW-1:0]    bit_count;  // bits collected in the current partial word

  modport master (
    output enable,
    output din,
    output clear,
    output ack,
    input  data,
    input  valid,
    input  busy,
    input  overrun,
    input  bit_count
  );

  modport slave (
    input  enable,
    input  din,
    input  clear,
    input  ack,
    output data,
    output valid,
    output busy,
    output overrun,
    output bit_count
  );

endinterface

// File: rtl/word_receiver.sv
// Serial-to-parallel capture stage. Shifts one bit per enabled cycle, MSB
// first, into a WIDTH-1 bit shift register; the WIDTH-th bit completes the
// word, which is loaded into a separate output register and offered to the
// consumer with a valid/ack handshake. Reception continues while a word is
// held, so a completed word that finds the output register still occupied
// is dropped and flagged as a sticky overrun.
module word_receiver #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  word_receiver_if.slave    bus_if
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // State and datapath registers
  state_e           r_state;
  logic [WIDTH-2:0] r_sh;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;

  // Next-state values
  state_e           w_state_d;
  logic [WIDTH-2:0] w_sh_d;
  logic [CW-1:0]    w_count_d;
  logic [WIDTH-1:0] w_data_d;
  logic             w_valid_d;
  logic             w_overrun_d;

  // Decoded events
  logic [WIDTH-1:0] w_word;      // shift register with the incoming bit appended
  logic             w_last_bit;  // the next enabled sample completes the word
  logic             w_sample;    // enabled sample that is not discarded by clear
  logic             w_complete;  // this cycle's sample completes a word

  // {sh, in} serves both as the shifted register (low WIDTH-1 bits) and as
  // the completed word, which keeps WIDTH == 2 free of empty slices.
  assign w_word     = {r_sh, bus_if.din};
  assign w_last_bit = (r_count == CW'(WIDTH - 1));
  assign w_sample   = bus_if.enable & ~bus_if.clear;
  assign w_complete = w_sample & w_last_bit;

  // Next-state logic: FSM, bit counter, shift register and output handshake
  always_comb begin
    w_state_d   = r_state;
    w_sh_d      = r_sh;
    w_count_d   = r_count;
    w_data_d    = r_data;
    w_valid_d   = r_valid;
    w_overrun_d = r_overrun;

    // clear wins over any sample in the same cycle, including completion
    if (bus_if.clear) begin
      w_count_d = '0;
      w_state_d = StIdle;
    end else if (bus_if.enable) begin
      if (w_last_bit) begin
        w_count_d = '0;
        w_state_d = StIdle;
      end else begin
        w_sh_d    = w_word[WIDTH-2:0];
        w_count_d = r_count + CW'(1);
        w_state_d = StShift;
      end
    end

    // A same-cycle ack frees the output register for the new word, so valid
    // stays high without a gap.
    if (w_complete) begin
      if (!r_valid || bus_if.ack) begin
        w_data_d  = w_word;
        w_valid_d = 1'b1;
      end else begin
        w_overrun_d = 1'b1;
      end
    end else if (bus_if.ack && r_valid) begin
      w_valid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_sh      <= '0;
      r_count   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_sh      <= w_sh_d;
      r_count   <= w_count_d;
      r_data    <= w_data_d;
      r_valid   <= w_valid_d;
      r_overrun <= w_overrun_d;
    end
  end

  // All outputs come straight from registers
  assign bus_if.data      = r_data;
  assign bus_if.valid     = r_valid;
  assign bus_if.busy      = (r_state == StShift);
  assign bus_if.overrun   = r_overrun;
  assign bus_if.bit_count = r_count;

endmodule

// File: tb/tb_word_receiver.sv
// Self-checking bench for word_receiver: a table of directed word transfers,
// hand-written clear/reset sequences, then randomized traffic, all compared
// every cycle against a bit-queue reference model.
module tb_word_receiver;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  word_receiver_if #(.WIDTH(W)) bus_if ();

  word_receiver #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus_if  (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: partial word kept as a queue of received bits
  bit           m_bits[$];
  logic [W-1:0] m_data;
  bit           m_valid;
  bit           m_ov;

  typedef struct {
    logic [31:0] word;
    bit          gaps;      // idle cycle between enabled samples
    bit          pre_ack;   // ack the held word before streaming
    bit          ack_last;  // ack together with the final bit
    logic [31:0] exp_data;
    bit          exp_valid;
    bit          exp_ov;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit b, input bit clr,
                            input bit ack);
    logic [W-1:0] word;
    bit           done;
    done = 1'b0;
    word = '0;
    if (!rst) begin
      m_bits.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ov    = 1'b0;
      return;
    end
    if (clr) begin
      m_bits.delete();
    end else if (en) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        foreach (m_bits[i]) word = (word << 1) | W'(m_bits[i]);
        m_bits.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_valid || ack) begin
        m_data  = word;
        m_valid = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end else if (ack && m_valid) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: drive, advance model on the edge, compare 1 time unit later
  task automatic cycle(input bit rst, input bit en, input bit b, input bit clr, input bit ack);
    rst_n         = rst;
    bus_if.enable = en;
    bus_if.din    = b;
    bus_if.clear  = clr;
    bus_if.ack    = ack;
    @(posedge clk);
    model_step(rst, en, b, clr, ack);
    #1;
    check("data",      64'(bus_if.data),      64'(m_data));
    check("valid",     64'(bus_if.valid),     64'(m_valid));
    check("overrun",   64'(bus_if.overrun),   64'(m_ov));
    check("busy",      64'(bus_if.busy),      64'(m_bits.size() != 0));
    check("bit_count", 64'(bus_if.bit_count), 64'(m_bits.size()));
  endtask

  task automatic send_word(input logic [31:0] word, input bit gaps, input bit ack_last);
    for (int i = W - 1; i >= 0; i--) begin
      if (gaps && i != W - 1) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, word[i], 1'b0, ack_last && (i == 0));
    end
  endtask

  initial begin
    vecs[0] = '{32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[1] = '{32'h80000001, 1'b1, 1'b1, 1'b0, 32'h80000001, 1'b1, 1'b0};
    vecs[2] = '{32'h12345678, 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b1, 1'b0};
    vecs[3] = '{32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0};
    vecs[4] = '{32'h11111111, 1'b0, 1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0};
    vecs[5] = '{32'h22222222, 1'b0, 1'b0, 1'b0, 32'h11111111, 1'b1, 1'b1};

    // Reset state, with other inputs active to show reset overrides them
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rst data",      64'(bus_if.data),      64'h0);
    check("rst valid",     64'(bus_if.valid),     64'h0);
    check("rst busy",      64'(bus_if.busy),      64'h0);
    check("rst bit_count", 64'(bus_if.bit_count), 64'h0);

    // Directed word transfers
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].pre_ack) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      send_word(vecs[v].word, vecs[v].gaps, vecs[v].ack_last);
      check($sformatf("vec%0d data", v),      64'(bus_if.data),      64'(vecs[v].exp_data));
      check($sformatf("vec%0d valid", v),     64'(bus_if.valid),     64'(vecs[v].exp_valid));
      check($sformatf("vec%0d overrun", v),   64'(bus_if.overrun),   64'(vecs[v].exp_ov));
      check($sformatf("vec%0d bit_count", v), 64'(bus_if.bit_count), 64'h0);
      check($sformatf("vec%0d busy", v),      64'(bus_if.busy),      64'h0);
    end

    // Ack after overrun: valid drops, overrun is sticky
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr ack valid",   64'(bus_if.valid),   64'h0);
    check("ovr ack overrun", 64'(bus_if.overrun), 64'h1);

    // Clear mid-word: 10 ones, then clear together with an enabled bit
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pre-clear bit_count", 64'(bus_if.bit_count), 64'd10);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("clear bit_count", 64'(bus_if.bit_count), 64'h0);
    check("clear busy",      64'(bus_if.busy),      64'h0);
    send_word(32'h0F0F0F0F, 1'b0, 1'b0);
    check("clear next data",  64'(bus_if.data),  64'h0F0F0F0F);
    check("clear next valid", 64'(bus_if.valid), 64'h1);

    // Reset mid-word with a held word
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(32'hAAAAAAAA, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'(i & 1), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("midrst data",      64'(bus_if.data),      64'h0);
    check("midrst valid",     64'(bus_if.valid),     64'h0);
    check("midrst overrun",   64'(bus_if.overrun),   64'h0);
    check("midrst busy",      64'(bus_if.busy),      64'h0);
    check("midrst bit_count", 64'(bus_if.bit_count), 64'h0);
    send_word(32'h55555555, 1'b0, 1'b0);
    check("postrst data",  64'(bus_if.data),  64'h55555555);
    check("postrst valid", 64'(bus_if.valid), 64'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 9) < 7),
            1'($urandom),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) < 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
